mrc_host_sequencer: RTL and testbench
=====================================

Name: mrc_host_sequencer

Overview:
- Host-side counterpart of the MRC control FSM. It drives the start/flagx/flagy/load/ready operand-prompt protocol on behalf of an upstream command source.
- Accepts one command (op plus operands) through a valid/ready handshake.
- Sequences start, then one load pulse per prompted operand, then captures the MRC result on its ready pulse.
- Returns the result (or a timeout indication) through a valid/ready response port.

Parameters:
- WORD_LENGTH, 16, operand width; MRC result width is 2*WORD_LENGTH.
- TIMEOUT, 1023, maximum cycles spent in any single wait state before aborting; must be ≥ 4*WORD_LENGTH + 16.
- TO_BITS, 10, width of the timeout counter; 2**TO_BITS must exceed TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer idle, can accept a command.
- cmd_op  in  1  0 = multiply, 1 = square root.
- cmd_x  in  WORD_LENGTH  first operand.
- cmd_y  in  WORD_LENGTH  second operand; ignored when cmd_op = 1.
- start  out  1  start pulse to MRC.
- op  out  1  operation select to MRC.
- load  out  1  operand load pulse to MRC.
- data_out  out  WORD_LENGTH  operand bus to MRC.
- flagx  in  1  MRC requests operand X.
- flagy  in  1  MRC requests operand Y.
- mrc_ready  in  1  MRC one-cycle done pulse.
- mrc_result  in  2*WORD_LENGTH  MRC result, valid while mrc_ready = 1.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  downstream accepts response.
- rsp_result  out  2*WORD_LENGTH  captured result.
- rsp_timeout  out  1  response is an abort, not a result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, reset = 0):
  - State IDLE; all outputs 0 except cmd_ready = 1.
  - Latched cmd_op/x/y cleared; timeout counter cleared.
- All protocol outputs (start, load, op, data_out, cmd_ready, rsp_*, busy) are Moore-decoded from registered state and latched operands. There are no combinational input-to-output paths.
- Accept: cmd_valid & cmd_ready at an edge latches op, x, y and moves to START.
- States and transitions:
  - IDLE: cmd_ready = 1; on accept -> START.
  - START: start = 1 for exactly one cycle -> WAIT_X.
  - WAIT_X: flagx = 1 -> LOAD_X; timeout -> RESP with abort.
  - LOAD_X: load = 1 for exactly one cycle. If op = 0 -> WAIT_Y, else -> WAIT_DONE. Unconditional; flagx still high here is ignored.
  - WAIT_Y: flagy = 1 -> LOAD_Y; timeout -> RESP with abort.
  - LOAD_Y: load = 1 for one cycle -> WAIT_DONE.
  - WAIT_DONE: mrc_ready = 1 -> capture mrc_result into rsp_result, clear rsp_timeout, -> RESP. Timeout -> RESP with rsp_result = 0, rsp_timeout = 1.
  - RESP: rsp_valid = 1, held stable together with rsp_result and rsp_timeout until rsp_ready = 1; then -> IDLE.
- op output: equals the latched cmd_op from START through WAIT_DONE; 0 in IDLE and RESP.
- data_out schedule:
  - X in START, WAIT_X, LOAD_X, WAIT_Y, so X stays stable through the MRC capture cycle after load.
  - Y in LOAD_Y and WAIT_DONE for multiply.
  - X in WAIT_DONE for square root.
  - 0 in IDLE and RESP.
- Latency, multiply with an immediately responding MRC:
  - Accept at edge 0; start high in cycle 1.
  - flagx seen at edge 2; load high in cycle 3.
  - flagy seen at edge 5; load high in cycle 6.
- Timeout counter:
  - Cleared on entry to every wait state; increments each cycle in WAIT_X, WAIT_Y and WAIT_DONE.
  - Abort when the count reaches TIMEOUT.
- Boundary conditions:
  - mrc_ready and the timeout in the same cycle: the result wins, no abort.
  - mrc_ready, flagx or flagy outside their own wait state: ignored.
  - flagy seen in WAIT_X: ignored.
  - Reset mid-operation: immediate return to IDLE. The MRC shares the reset, so no cleanup handshake is required.
  - rsp_ready high in any state other than RESP: no effect.
  - cmd_valid outside IDLE: not accepted; the command is held by upstream.

Decomposition:
- Shared package mrc_pkg:
  - state encoding localparams (IDLE..RESP, 3 bits);
  - OP_MULT = 0, OP_SQRT = 1;
  - a WORD_LENGTH default constant, also used by the MRC top.
- One sub-module, mrc_timeout_counter:
  - parameters TO_BITS, TIMEOUT;
  - ports clk, reset, clear, enable, flag;
  - flag = (count == TIMEOUT).
- Everything else stays in one always-block FSM plus its output decode.

Test Plan:
- Multiply, behavioural MRC model: cmd op = 0, x = 7, y = 9.
  - Exactly one start pulse and two load pulses.
  - data_out = 7 at the first load and the cycle after; data_out = 9 at the second load.
  - rsp_result = 63, rsp_timeout = 0.
- Square root, op = 1, x = 144:
  - Single load pulse; data_out = 144 held through WAIT_DONE.
  - No response to a stray flagy.
  - rsp_result equals the model value 12.
- Model never raises flagx, TIMEOUT = 20:
  - rsp_valid asserted 20 cycles after WAIT_X entry, rsp_timeout = 1, rsp_result = 0.
  - Then accepts a new command and completes 3*5 = 15.
- Backpressure: rsp_ready held low for 5 cycles in RESP.
  - rsp_valid and rsp_result stable throughout; cmd_ready = 0 throughout.
  - IDLE one cycle after rsp_ready = 1.
- Reset asserted in WAIT_Y:
  - Immediately all outputs 0, cmd_ready = 1, busy = 0.
  - After release, a new multiply 2*3 returns 6.
- mrc_ready pulses in the same cycle the timeout flag fires:
  - rsp_timeout = 0 and rsp_result = the model result (e.g. 0x1234).

Source files
------------

// File: rtl/mrc_host_sequencer_pkg.sv
// Shared definitions for the MRC host sequencer: FSM state encoding,
// operation codes and the default operand width used across the MRC.
package mrc_host_sequencer_pkg;

    localparam int MRC_WORD_LENGTH = 16;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_SQRT = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_X    = 3'd2,
        LOAD_X    = 3'd3,
        WAIT_Y    = 3'd4,
        LOAD_Y    = 3'd5,
        WAIT_DONE = 3'd6,
        RESP      = 3'd7
    } seq_state_t;

    function automatic logic is_wait_state(input seq_state_t s);
        return (s == WAIT_X) || (s == WAIT_Y) || (s == WAIT_DONE);
    endfunction

endpackage

// File: rtl/mrc_host_sequencer_if.sv
// Command, response and MRC operand-prompt signals of the host sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface mrc_host_sequencer_if
    import mrc_host_sequencer_pkg::*;
#(
    parameter int WORD_LENGTH = MRC_WORD_LENGTH
);
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic                       cmd_op;
    logic [WORD_LENGTH-1:0]     cmd_x;
    logic [WORD_LENGTH-1:0]     cmd_y;

    logic                       start;
    logic                       op;
    logic                       load;
    logic [WORD_LENGTH-1:0]     data_out;
    logic                       flagx;
    logic                       flagy;
    logic                       mrc_ready;
    logic [2*WORD_LENGTH-1:0]   mrc_result;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [2*WORD_LENGTH-1:0]   rsp_result;
    logic                       rsp_timeout;

    modport master (
        input  cmd_valid, cmd_op, cmd_x, cmd_y,
        output cmd_ready,
        output start, op, load, data_out,
        input  flagx, flagy, mrc_ready, mrc_result,
        output rsp_valid, rsp_result, rsp_timeout,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_x, cmd_y,
        input  cmd_ready,
        input  start, op, load, data_out,
        output flagx, flagy, mrc_ready, mrc_result,
        input  rsp_valid, rsp_result, rsp_timeout,
        output rsp_ready
    );

endinterface

// File: rtl/mrc_timeout_counter.sv
// Wait-state watchdog: counts while enabled, raises flag once the count
// equals TIMEOUT and holds there until cleared.
module mrc_timeout_counter #(
    parameter int TO_BITS = 10,
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic flag
);

    logic [TO_BITS-1:0] count;

    assign flag = (count == TO_BITS'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !flag) begin
            count <= count + TO_BITS'(1);
        end
    end

endmodule

// File: rtl/mrc_host_sequencer.sv
// Host-side driver of the MRC operand-prompt protocol: takes one command,
// feeds operands on flagx/flagy prompts and returns the result or an abort.
module mrc_host_sequencer
    import mrc_host_sequencer_pkg::*;
#(
    parameter int WORD_LENGTH = MRC_WORD_LENGTH,
    parameter int TIMEOUT     = 1023,
    parameter int TO_BITS     = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    mrc_host_sequencer_if.master  bus,
    output logic                  busy
);

    seq_state_t                 state;
    logic                       op_q;
    logic [WORD_LENGTH-1:0]     x_q;
    logic [WORD_LENGTH-1:0]     y_q;
    logic [2*WORD_LENGTH-1:0]   result_q;
    logic                       timeout_q;

    logic                       waiting;
    logic                       entering;
    logic                       wait_exit;
    logic                       to_flag;

    // The count includes the current wait cycle: it is zeroed on leaving a
    // wait state and already steps on the single-cycle state that enters one.
    always_comb begin
        waiting   = is_wait_state(state);
        entering  = (state == START) || (state == LOAD_X) || (state == LOAD_Y);
        wait_exit = waiting && (to_flag
                                || (state == WAIT_X    && bus.flagx)
                                || (state == WAIT_Y    && bus.flagy)
                                || (state == WAIT_DONE && bus.mrc_ready));
    end

    mrc_timeout_counter #(
        .TO_BITS (TO_BITS),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!(waiting || entering) || wait_exit),
        .enable (waiting || entering),
        .flag   (to_flag)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_q      <= OP_MULT;
            x_q       <= '0;
            y_q       <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    op_q  <= bus.cmd_op;
                    x_q   <= bus.cmd_x;
                    y_q   <= bus.cmd_y;
                    state <= START;
                end
                START:  state <= WAIT_X;
                WAIT_X: if (bus.flagx) begin
                    state <= LOAD_X;
                end else if (to_flag) begin
                    result_q  <= '0;
                    timeout_q <= 1'b1;
                    state     <= RESP;
                end
                LOAD_X: state <= (op_q == OP_SQRT) ? WAIT_DONE : WAIT_Y;
                WAIT_Y: if (bus.flagy) begin
                    state <= LOAD_Y;
                end else if (to_flag) begin
                    result_q  <= '0;
                    timeout_q <= 1'b1;
                    state     <= RESP;
                end
                LOAD_Y: state <= WAIT_DONE;
                // A result arriving on the timeout cycle still counts as success.
                WAIT_DONE: if (bus.mrc_ready) begin
                    result_q  <= bus.mrc_result;
                    timeout_q <= 1'b0;
                    state     <= RESP;
                end else if (to_flag) begin
                    result_q  <= '0;
                    timeout_q <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (bus.rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // X stays on the bus through WAIT_Y so the MRC can capture it after load.
    always_comb begin
        bus.cmd_ready   = (state == IDLE);
        bus.start       = (state == START);
        bus.load        = (state == LOAD_X) || (state == LOAD_Y);
        bus.op          = (state == IDLE || state == RESP) ? 1'b0 : op_q;
        bus.rsp_valid   = (state == RESP);
        bus.rsp_result  = (state == RESP) ? result_q : '0;
        bus.rsp_timeout = (state == RESP) && timeout_q;
        busy            = (state != IDLE);
        case (state)
            START, WAIT_X, LOAD_X, WAIT_Y: bus.data_out = x_q;
            LOAD_Y:                        bus.data_out = y_q;
            WAIT_DONE:                     bus.data_out = (op_q == OP_SQRT) ? x_q : y_q;
            default:                       bus.data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_mrc_host_sequencer.sv
// Directed bench for mrc_host_sequencer with a behavioural MRC model that
// answers start/load with flagx/flagy prompts and a delayed ready pulse.
module tb_mrc_host_sequencer;

    localparam int WL = 16;
    localparam int TO = 20;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mrc_host_sequencer_if #(.WORD_LENGTH(WL)) bus ();

    mrc_host_sequencer #(
        .WORD_LENGTH (WL),
        .TIMEOUT     (TO),
        .TO_BITS     (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    // MRC model controls
    logic model_no_flagx;
    logic model_stray_flagy;
    int   model_delay;

    typedef enum int {M_IDLE, M_FX, M_GAP, M_FY, M_CALC, M_DONE} m_state_t;
    m_state_t    m_state;
    logic        m_op;
    logic [31:0] m_x, m_y;
    int          m_cnt;

    function automatic logic [31:0] isqrt(input logic [31:0] v);
        logic [31:0] r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Behavioural MRC: prompt X the cycle after start, Y one idle cycle
    // after the X load, then pulse ready model_delay+1 cycles after the last load.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_state        <= M_IDLE;
            m_op           <= 1'b0;
            m_x            <= '0;
            m_y            <= '0;
            m_cnt          <= 0;
            bus.flagx      <= 1'b0;
            bus.flagy      <= 1'b0;
            bus.mrc_ready  <= 1'b0;
            bus.mrc_result <= '0;
        end else if (bus.start) begin
            m_state       <= M_FX;
            m_op          <= bus.op;
            bus.flagx     <= !model_no_flagx;
            bus.flagy     <= model_stray_flagy;
            bus.mrc_ready <= 1'b0;
        end else begin
            case (m_state)
                M_FX: if (bus.load) begin
                    m_x       <= 32'(bus.data_out);
                    bus.flagx <= 1'b0;
                    m_cnt     <= 0;
                    m_state   <= m_op ? M_CALC : M_GAP;
                end
                M_GAP: begin
                    bus.flagy <= 1'b1;
                    m_state   <= M_FY;
                end
                M_FY: if (bus.load) begin
                    m_y       <= 32'(bus.data_out);
                    bus.flagy <= 1'b0;
                    m_cnt     <= 0;
                    m_state   <= M_CALC;
                end
                M_CALC: if (m_cnt == model_delay) begin
                    bus.mrc_ready  <= 1'b1;
                    bus.mrc_result <= m_op ? isqrt(m_x) : m_x * m_y;
                    m_state        <= M_DONE;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                M_DONE: begin
                    bus.mrc_ready  <= 1'b0;
                    bus.mrc_result <= '0;
                    bus.flagy      <= 1'b0;
                    m_state        <= M_IDLE;
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // Observations gathered by run_cmd; cycle 1 is the cycle after the accept edge.
    int          mon_starts, mon_loads, mon_load1_cyc, mon_load2_cyc, mon_rsp_cyc;
    logic [15:0] mon_d_load1, mon_d_after1, mon_d_load2;
    logic        mon_held;

    task automatic run_cmd(input logic op, input logic [15:0] x, input logic [15:0] y);
        mon_starts = 0; mon_loads = 0; mon_load1_cyc = -1; mon_load2_cyc = -1;
        mon_rsp_cyc = -1; mon_held = 1'b1;
        mon_d_load1 = '0; mon_d_after1 = '0; mon_d_load2 = '0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_x = x; bus.cmd_y = y;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (bus.start) mon_starts++;
            if (bus.rsp_valid) begin
                mon_rsp_cyc = cyc;
                break;
            end
            if (mon_loads >= 1 && bus.data_out !== mon_d_load1) mon_held = 1'b0;
            if (mon_loads >= 1 && cyc == mon_load1_cyc + 1) mon_d_after1 = bus.data_out;
            if (bus.load) begin
                mon_loads++;
                if (mon_loads == 1) begin mon_load1_cyc = cyc; mon_d_load1 = bus.data_out; end
                if (mon_loads == 2) begin mon_load2_cyc = cyc; mon_d_load2 = bus.data_out; end
            end
        end
        checks++;
        if (mon_rsp_cyc < 0) begin
            failures++;
            $display("[TB] FAIL rsp_wait: no rsp_valid within 100 cycles, required a response");
        end
    endtask

    task automatic drain_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if ({bus.start, bus.load, bus.op, bus.data_out, bus.rsp_valid, bus.rsp_result, bus.rsp_timeout} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: start=%b load=%b op=%b data=%0d rsp_valid=%b result=%0d timeout=%b, expected all 0",
                     bus.start, bus.load, bus.op, bus.data_out, bus.rsp_valid, bus.rsp_result, bus.rsp_timeout);
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_multiply();
        model_delay = 0;
        run_cmd(1'b0, 16'd7, 16'd9);
        checks++;
        if (mon_starts !== 1) begin failures++; $display("[TB] FAIL mult_starts: got %0d expected 1", mon_starts); end
        checks++;
        if (mon_loads !== 2) begin failures++; $display("[TB] FAIL mult_loads: got %0d expected 2", mon_loads); end
        checks++;
        if (mon_load1_cyc !== 3 || mon_load2_cyc !== 6) begin
            failures++; $display("[TB] FAIL mult_load_cycles: got %0d/%0d expected 3/6", mon_load1_cyc, mon_load2_cyc);
        end
        checks++;
        if (mon_d_load1 !== 16'd7 || mon_d_after1 !== 16'd7) begin
            failures++; $display("[TB] FAIL mult_data_x: got %0d/%0d expected 7/7", mon_d_load1, mon_d_after1);
        end
        checks++;
        if (mon_d_load2 !== 16'd9) begin failures++; $display("[TB] FAIL mult_data_y: got %0d expected 9", mon_d_load2); end
        checks++;
        if (bus.rsp_result !== 32'd63) begin failures++; $display("[TB] FAIL mult_result: got %0d expected 63", bus.rsp_result); end
        checks++;
        if (bus.rsp_timeout !== 1'b0) begin failures++; $display("[TB] FAIL mult_timeout: got %b expected 0", bus.rsp_timeout); end
        checks++;
        if (mon_rsp_cyc !== 9) begin failures++; $display("[TB] FAIL mult_rsp_cycle: got %0d expected 9", mon_rsp_cyc); end
        drain_rsp();
    endtask

    task automatic test_sqrt();
        model_stray_flagy = 1'b1;
        run_cmd(1'b1, 16'd144, 16'd5);
        model_stray_flagy = 1'b0;
        checks++;
        if (mon_loads !== 1 || mon_load1_cyc !== 3) begin
            failures++; $display("[TB] FAIL sqrt_loads: got %0d loads at cycle %0d expected 1 at cycle 3", mon_loads, mon_load1_cyc);
        end
        checks++;
        if (mon_d_load1 !== 16'd144 || mon_held !== 1'b1) begin
            failures++; $display("[TB] FAIL sqrt_data_held: got %0d held=%b expected 144 held=1", mon_d_load1, mon_held);
        end
        checks++;
        if (bus.rsp_result !== 32'd12 || bus.rsp_timeout !== 1'b0) begin
            failures++; $display("[TB] FAIL sqrt_result: got %0d timeout=%b expected 12 timeout=0", bus.rsp_result, bus.rsp_timeout);
        end
        drain_rsp();
    endtask

    task automatic test_timeout();
        model_no_flagx = 1'b1;
        run_cmd(1'b0, 16'd3, 16'd5);
        model_no_flagx = 1'b0;
        checks++;
        if (mon_rsp_cyc !== 22) begin failures++; $display("[TB] FAIL timeout_cycle: got %0d expected 22", mon_rsp_cyc); end
        checks++;
        if (bus.rsp_timeout !== 1'b1 || bus.rsp_result !== 32'd0) begin
            failures++; $display("[TB] FAIL timeout_rsp: got timeout=%b result=%0d expected 1/0", bus.rsp_timeout, bus.rsp_result);
        end
        checks++;
        if (mon_loads !== 0) begin failures++; $display("[TB] FAIL timeout_loads: got %0d expected 0", mon_loads); end
        drain_rsp();
        run_cmd(1'b0, 16'd3, 16'd5);
        checks++;
        if (bus.rsp_result !== 32'd15 || bus.rsp_timeout !== 1'b0) begin
            failures++; $display("[TB] FAIL after_timeout_result: got %0d timeout=%b expected 15/0", bus.rsp_result, bus.rsp_timeout);
        end
        drain_rsp();
    endtask

    task automatic test_backpressure();
        run_cmd(1'b0, 16'd11, 16'd13);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd143) begin
                failures++; $display("[TB] FAIL bp_hold[%0d]: got valid=%b result=%0d expected 1/143", i, bus.rsp_valid, bus.rsp_result);
            end
            checks++;
            if (bus.cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_cmd_ready[%0d]: got %b expected 0", i, bus.cmd_ready); end
        end
        drain_rsp();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL bp_release: got cmd_ready=%b rsp_valid=%b busy=%b expected 1/0/0", bus.cmd_ready, bus.rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_op = 1'b0; bus.cmd_x = 16'd100; bus.cmd_y = 16'd200;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || bus.data_out !== 16'd100) begin
            failures++; $display("[TB] FAIL wait_y_state: got busy=%b data=%0d expected 1/100", busy, bus.data_out);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL midreset_idle: got cmd_ready=%b busy=%b expected 1/0", bus.cmd_ready, busy);
        end
        checks++;
        if ({bus.start, bus.load, bus.op, bus.data_out, bus.rsp_valid, bus.rsp_result, bus.rsp_timeout} !== '0) begin
            failures++; $display("[TB] FAIL midreset_outputs: data=%0d load=%b rsp_valid=%b expected all 0", bus.data_out, bus.load, bus.rsp_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        run_cmd(1'b0, 16'd2, 16'd3);
        checks++;
        if (bus.rsp_result !== 32'd6 || bus.rsp_timeout !== 1'b0) begin
            failures++; $display("[TB] FAIL midreset_result: got %0d timeout=%b expected 6/0", bus.rsp_result, bus.rsp_timeout);
        end
        drain_rsp();
    endtask

    task automatic test_ready_vs_timeout();
        model_delay = 18;
        run_cmd(1'b0, 16'd2, 16'd2330);
        model_delay = 0;
        checks++;
        if (mon_rsp_cyc !== 27) begin failures++; $display("[TB] FAIL tie_cycle: got %0d expected 27", mon_rsp_cyc); end
        checks++;
        if (bus.rsp_timeout !== 1'b0 || bus.rsp_result !== 32'h1234) begin
            failures++; $display("[TB] FAIL tie_result: got %h timeout=%b expected 1234/0", bus.rsp_result, bus.rsp_timeout);
        end
        drain_rsp();
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0; bus.rsp_ready = 1'b0;
        model_no_flagx = 1'b0; model_stray_flagy = 1'b0; model_delay = 0;
        test_reset();
        test_multiply();
        test_sqrt();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_ready_vs_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
